// File: rtl/multicycle_control_if.sv
// multicycle_control_if: bundle between the multi-cycle control unit and the
// datapath/memory. The controller (master) consumes the opcode field, the ALU
// zero flag and the memory ready handshake, and drives every datapath strobe
// plus the debug state and retired-instruction count.
interface multicycle_control_if #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic [OP_W-1:0]    opcode;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic [1:0]         pc_src;
    logic               ir_write;
    logic               mem_read;
    logic               mem_write;
    logic               iord;
    logic               reg_write;
    logic               mem_to_reg;
    logic               reg_dst;
    logic               alu_src;
    logic [ALUOP_W-1:0] alu_op;
    logic               illegal;
    logic [2:0]         state;
    logic [CNT_W-1:0]   instr_count;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, reg_dst, alu_src, alu_op, illegal,
               state, instr_count
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, pc_src, ir_write, mem_read, mem_write, iord,
               reg_write, mem_to_reg, reg_dst, alu_src, alu_op, illegal,
               state, instr_count
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the 14-instruction
// ISA. Strobes are decoded from the state and the opcode latched in DECODE; only
// the FETCH load strobes (mem_ready) and the branch pc_write (zero) look at live
// inputs. Also counts retired instructions (wrapping).
// Optional build macro MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN: an illegal opcode
// parks the unit in TRAP until reset instead of being skipped as a NOP.
module multicycle_control #(
    parameter int OP_W    = 4,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    multicycle_control_if.master bus
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        , ST_TRAP = 3'd6
`endif
    } state_t;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_BEQ  = 4'h3;
    localparam logic [3:0] OP_BNE  = 4'h4;
    localparam logic [3:0] OP_JMP  = 4'h5;
    localparam logic [3:0] OP_LW   = 4'h6;
    localparam logic [3:0] OP_LUI  = 4'h7;
    localparam logic [3:0] OP_OR   = 4'h8;
    localparam logic [3:0] OP_XOR  = 4'h9;
    localparam logic [3:0] OP_SLTI = 4'hA;
    localparam logic [3:0] OP_SLL  = 4'hB;
    localparam logic [3:0] OP_SRL  = 4'hC;
    localparam logic [3:0] OP_SW   = 4'hD;

    state_t           state_r;
    logic [3:0]       op_r;
    logic [CNT_W-1:0] count_r;
    logic             legal_s;

    // Legal means no bits above [3:0] and not one of the two unused codes E/F.
    function automatic logic opcode_legal(input logic [OP_W-1:0] op);
        return ((op >> 4) == {OP_W{1'b0}}) && (op[3:0] < 4'hE);
    endfunction

    // 4-bit ALU operation per instruction class.
    function automatic logic [3:0] alu_code(input logic [3:0] op);
        case (op)
            OP_LW, OP_SW: return 4'b0001;
            OP_BEQ:       return 4'b0010;
            OP_ADDI:      return 4'b0011;
            OP_BNE:       return 4'b0100;
            OP_LUI:       return 4'b0101;
            OP_SLL:       return 4'b0110;
            OP_SRL:       return 4'b1000;
            OP_SLTI:      return 4'b1001;
            OP_JMP:       return 4'b1111;
            default:      return 4'b0000;
        endcase
    endfunction

    // Instructions whose second ALU operand is the immediate.
    function automatic logic uses_imm(input logic [3:0] op);
        case (op)
            OP_ADDI, OP_LW, OP_LUI, OP_SLTI, OP_SLL, OP_SRL, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // Register-register instructions write the rd field.
    function automatic logic writes_rd(input logic [3:0] op);
        case (op)
            OP_R, OP_AND, OP_OR, OP_XOR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign legal_s         = opcode_legal(bus.opcode);
    assign bus.state       = state_r;
    assign bus.instr_count = count_r;

    // Sequencer: state, latched opcode and retired-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_INIT;
            op_r    <= 4'h0;
            count_r <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                ST_INIT: state_r <= ST_FETCH;
                ST_FETCH: begin
                    if (bus.mem_ready) state_r <= ST_DECODE;
                    else               state_r <= ST_FETCH;
                end
                ST_DECODE: begin
                    op_r <= bus.opcode[3:0];
                    if (legal_s) begin
                        state_r <= ST_EXEC;
                    end else begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                        state_r <= ST_TRAP;
`else
                        state_r <= ST_FETCH;
`endif
                    end
                end
                ST_EXEC: begin
                    case (op_r)
                        OP_BEQ, OP_BNE, OP_JMP: begin
                            state_r <= ST_FETCH;
                            count_r <= count_r + CNT_W'(1'b1);
                        end
                        OP_LW, OP_SW: state_r <= ST_MEM;
                        default:      state_r <= ST_WB;
                    endcase
                end
                ST_MEM: begin
                    if (!bus.mem_ready) begin
                        state_r <= ST_MEM;
                    end else if (op_r == OP_SW) begin
                        state_r <= ST_FETCH;
                        count_r <= count_r + CNT_W'(1'b1);
                    end else begin
                        state_r <= ST_WB;
                    end
                end
                ST_WB: begin
                    state_r <= ST_FETCH;
                    count_r <= count_r + CNT_W'(1'b1);
                end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                ST_TRAP: state_r <= ST_TRAP;
`endif
                default: state_r <= ST_INIT;
            endcase
        end
    end

    // Strobe decode from state and latched opcode; INIT (and reset) drives all zero.
    always_comb begin
        bus.pc_write   = 1'b0;
        bus.pc_src     = 2'b00;
        bus.ir_write   = 1'b0;
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.iord       = 1'b0;
        bus.reg_write  = 1'b0;
        bus.mem_to_reg = 1'b0;
        bus.reg_dst    = 1'b0;
        bus.alu_src    = 1'b0;
        bus.alu_op     = {ALUOP_W{1'b0}};
        bus.illegal    = 1'b0;
        case (state_r)
            ST_FETCH: begin
                bus.mem_read = 1'b1;
                if (bus.mem_ready) begin
                    bus.ir_write = 1'b1;
                    bus.pc_write = 1'b1;
                end else begin
                    bus.ir_write = 1'b0;
                    bus.pc_write = 1'b0;
                end
            end
            ST_DECODE: bus.illegal = ~legal_s;
            ST_EXEC: begin
                bus.alu_op  = ALUOP_W'(alu_code(op_r));
                bus.alu_src = uses_imm(op_r);
                case (op_r)
                    OP_BEQ: begin
                        bus.pc_write = bus.zero;
                        bus.pc_src   = 2'b01;
                    end
                    OP_BNE: begin
                        bus.pc_write = ~bus.zero;
                        bus.pc_src   = 2'b01;
                    end
                    OP_JMP: begin
                        bus.pc_write = 1'b1;
                        bus.pc_src   = 2'b10;
                    end
                    default: begin
                        bus.pc_write = 1'b0;
                    end
                endcase
            end
            ST_MEM: begin
                bus.iord      = 1'b1;
                bus.mem_read  = (op_r == OP_LW);
                bus.mem_write = (op_r == OP_SW);
            end
            ST_WB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = (op_r == OP_LW);
                bus.reg_dst    = writes_rd(op_r);
            end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            ST_TRAP: bus.illegal = 1'b1;
`endif
            default: begin
                bus.illegal = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: builds an expected per-cycle trace from the ISA rules
// (instruction -> list of cycles with inputs and required outputs), plays the
// inputs into the DUT and compares every output each cycle. OP_W=5 exercises
// the upper-bit illegal rule, ALUOP_W=5 the zero-extension, CNT_W=2 the wrap.
module tb_multicycle_control;
    localparam int OP_W    = 5;
    localparam int ALUOP_W = 5;
    localparam int CNT_W   = 2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_if #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) bus ();

    multicycle_control #(.OP_W(OP_W), .ALUOP_W(ALUOP_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [4:0] op;
        logic       zero;
        logic       rdy;
        logic [2:0] st;
        logic       pcw;
        logic [1:0] pcs;
        logic       irw, mrd, mwr, iord, rw, m2r, rdst, asrc;
        logic [4:0] aop;
        logic       ill;
        logic [1:0] cnt;
    } cyc_t;

    cyc_t  q[$];
    cyc_t  cur;
    int    n_cmp  = 0;
    int    n_bad  = 0;
    int    mcount = 0;
    int    cyc_no = 0;
    int    alu_tab [14] = '{0, 3, 0, 2, 4, 15, 1, 5, 0, 0, 9, 6, 8, 1};
    logic [15:0] src_set = 16'h3CC2;
    logic [15:0] dst_set = 16'h0305;

    function automatic logic [21:0] dut_vec();
        return {bus.state, bus.pc_write, bus.pc_src, bus.ir_write, bus.mem_read,
                bus.mem_write, bus.iord, bus.reg_write, bus.mem_to_reg, bus.reg_dst,
                bus.alu_src, bus.alu_op, bus.illegal, bus.instr_count};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic cyc_t blank(input logic [2:0] st);
        cyc_t c;
        c.op = 5'h0E; c.zero = 1'b1; c.rdy = 1'b1; c.st = st;
        c.pcw = 1'b0; c.pcs = 2'b00; c.irw = 1'b0; c.mrd = 1'b0; c.mwr = 1'b0;
        c.iord = 1'b0; c.rw = 1'b0; c.m2r = 1'b0; c.rdst = 1'b0; c.asrc = 1'b0;
        c.aop = 5'd0; c.ill = 1'b0; c.cnt = 2'(mcount);
        return c;
    endfunction

    function automatic void retire();
        mcount = (mcount + 1) % (1 << CNT_W);
    endfunction

    // Append the cycle-by-cycle expectation of one instruction.
    task automatic gen(input logic [4:0] op, input logic z, input int fw, input int mw);
        cyc_t       c;
        logic [3:0] lo;
        bit         legal;
        int         k;
        lo    = op[3:0];
        k     = int'(lo);
        legal = (op[4] == 1'b0) && (lo < 4'hE);
        for (int i = 0; i <= fw; i++) begin
            c = blank(3'd1); c.mrd = 1'b1;
            c.rdy = (i == fw); c.irw = (i == fw); c.pcw = (i == fw);
            q.push_back(c);
        end
        c = blank(3'd2); c.op = op; c.rdy = 1'b0; c.ill = !legal;
        q.push_back(c);
        if (!legal) begin
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            for (int i = 0; i < 3; i++) begin
                c = blank(3'd6); c.ill = 1'b1; c.op = op; c.rdy = 1'(i % 2);
                q.push_back(c);
            end
`endif
            return;
        end
        c = blank(3'd3); c.op = op ^ 5'h0F; c.zero = z;
        c.aop = 5'(alu_tab[k]); c.asrc = src_set[k];
        if (k == 3)      begin c.pcw = z;    c.pcs = 2'b01; end
        else if (k == 4) begin c.pcw = !z;   c.pcs = 2'b01; end
        else if (k == 5) begin c.pcw = 1'b1; c.pcs = 2'b10; end
        q.push_back(c);
        if (k >= 3 && k <= 5) begin retire(); return; end
        if (k == 6 || k == 13) begin
            for (int i = 0; i <= mw; i++) begin
                c = blank(3'd4); c.op = ~op; c.iord = 1'b1;
                c.mrd = (k == 6); c.mwr = (k == 13); c.rdy = (i == mw);
                q.push_back(c);
            end
            if (k == 13) begin retire(); return; end
        end
        c = blank(3'd5); c.op = ~op; c.rw = 1'b1; c.m2r = (k == 6); c.rdst = dst_set[k];
        q.push_back(c);
        retire();
    endtask

    task automatic cmp_cycle();
        logic [21:0] e;
        e = {cur.st, cur.pcw, cur.pcs, cur.irw, cur.mrd, cur.mwr, cur.iord, cur.rw,
             cur.m2r, cur.rdst, cur.asrc, cur.aop, cur.ill, cur.cnt};
        n_cmp++;
        if (dut_vec() !== e) begin
            n_bad++;
            $display("FAIL cycle %0d: got %b expected %b (st,pcw,pcs,irw,mrd,mwr,iord,rw,m2r,rdst,asrc,aop,ill,cnt)",
                     cyc_no, dut_vec(), e);
        end
    endtask

    // Drive each queued cycle just after the edge, compare on the falling edge.
    task automatic run_queue();
        while (q.size() > 0) begin
            @(posedge clk); #1;
            cur           = q.pop_front();
            rst_n         = 1'b1;
            bus.opcode    = cur.op;
            bus.zero      = cur.zero;
            bus.mem_ready = cur.rdy;
            @(negedge clk);
            cmp_cycle();
            cyc_no++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hold", 64'(dut_vec()), 64'd0);
        mcount = 0;
        q.push_back(blank(3'd0));
    endtask

    initial begin
        int sz;
        bus.opcode = 5'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;

        // Phase A: every instruction class, stalls, ignored inputs, illegal codes.
        do_reset();
        gen(5'h01, 1'b0, 0, 0);
        check("model_addi_states",
              64'({q[0].st, q[1].st, q[2].st, q[3].st, q[4].st}), 64'b000_001_010_011_101);
        check("model_addi_count", 64'(mcount), 64'd1);
        sz = q.size(); gen(5'h06, 1'b0, 0, 2);
        check("model_lw_len", 64'(q.size() - sz), 64'd7);
        sz = q.size(); gen(5'h03, 1'b1, 0, 0);
        check("model_beq_len", 64'(q.size() - sz), 64'd3);
        check("model_beq_pcw", 64'(q[q.size()-1].pcw), 64'd1);
        sz = q.size(); gen(5'h04, 1'b1, 0, 0);
        check("model_bne_len", 64'(q.size() - sz), 64'd3);
        check("model_bne_pcw", 64'(q[q.size()-1].pcw), 64'd0);
        gen(5'h05, 1'b0, 0, 0);
        gen(5'h00, 1'b0, 1, 0);
        gen(5'h02, 1'b0, 0, 0);
        gen(5'h08, 1'b1, 0, 0);
        gen(5'h09, 1'b0, 2, 0);
        gen(5'h07, 1'b0, 0, 0);
        gen(5'h0A, 1'b1, 0, 0);
        gen(5'h0B, 1'b0, 0, 0);
        gen(5'h0C, 1'b0, 0, 0);
        gen(5'h04, 1'b0, 0, 0);
        gen(5'h03, 1'b0, 0, 0);
        gen(5'h0D, 1'b0, 0, 1);
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        gen(5'h0F, 1'b0, 0, 0);
`else
        sz = mcount; gen(5'h0F, 1'b0, 0, 0);
        check("model_illegal_nocount", 64'(mcount), 64'(sz));
        gen(5'h0E, 1'b0, 0, 0);
        gen(5'h13, 1'b0, 0, 0);
        gen(5'h01, 1'b0, 0, 0);
`endif
        run_queue();
        @(posedge clk); #1;

        // Phase B: counter wrap with CNT_W=2, then reset in the middle of MEM.
        do_reset();
        gen(5'h0D, 1'b0, 0, 0); check("model_sw1_count", 64'(mcount), 64'd1);
        gen(5'h0D, 1'b0, 1, 0); check("model_sw2_count", 64'(mcount), 64'd2);
        gen(5'h0D, 1'b0, 0, 1); check("model_sw3_count", 64'(mcount), 64'd3);
        gen(5'h0D, 1'b0, 0, 0); check("model_sw4_count", 64'(mcount), 64'd0);
        run_queue();
        gen(5'h0D, 1'b0, 0, 5);
        while (q.size() > 5) void'(q.pop_back());
        run_queue();
        #1;
        check("pre_rst_state", 64'(bus.state), 64'd4);
        check("pre_rst_mem_write", 64'(bus.mem_write), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mem_write", 64'(bus.mem_write), 64'd0);
        check("rst_state", 64'(bus.state), 64'd0);
        check("rst_all_outputs", 64'(dut_vec()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end
endmodule

// File: doc/multicycle_control.md
# multicycle_control

Parametrised multi-cycle control unit replacing the single-cycle registered opcode decoder. Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states, and waits on a memory ready handshake. Drives the datapath strobes for the existing 14-instruction ISA. Sits between the instruction register and the datapath, and also counts retired instructions.

## Interface
- `OP_W`, default 4: opcode width. Values ≥ 4 are legal; bits above [3:0] must be 0, otherwise the opcode is illegal.
- `ALUOP_W`, default 4: ALU operation width. Values ≥ 4 are legal; codes are zero-extended.
- `CNT_W`, default 16: retired-instruction counter width.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `opcode` input OP_W: instruction register opcode field. Valid from DECODE onward.
- `zero` input 1: ALU zero flag. Sampled in EXEC.
- `mem_ready` input 1: memory completes the current read or write this cycle.
- `pc_write` output 1: PC load enable.
- `pc_src` output 2: PC source. 00 = PC+1, 01 = branch target, 10 = jump target.
- `ir_write` output 1: instruction register load.
- `mem_read` output 1: memory read request.
- `mem_write` output 1: memory write request.
- `iord` output 1: memory address select. 0 = PC, 1 = ALU result.
- `reg_write`, `mem_to_reg`, `reg_dst`, `alu_src` outputs, 1 bit each: same meaning as today's decoder.
- `alu_op` output ALUOP_W: ALU operation code.
- `illegal` output 1: an illegal opcode was decoded.
- `state` output 3: current state, for debug.
- `instr_count` output CNT_W: number of retired instructions.

## Operation
- States and encodings: INIT=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, TRAP=6.
- Opcode map:
  - 0 R-type, 1 addi, 2 and, 3 beq, 4 bne, 5 jmp, 6 lw, 7 lui
  - 8 or, 9 xor, A slti, B sll, C srl, D sw
  - E, F illegal
- Opcode latching: DECODE latches `opcode` into `op_q`. EXEC, MEM and WB use `op_q` only.
- `alu_op` per class (binary values):
  - R/and/or/xor 0000
  - lw/sw 0001
  - beq 0010
  - addi 0011
  - bne 0100
  - lui 0101
  - sll 0110
  - srl 1000
  - slti 1001
  - jmp 1111
- INIT: all outputs 0. Unconditionally goes to FETCH.
- FETCH: `mem_read`=1, `iord`=0.
  - Stays in FETCH while `mem_ready`=0.
  - In the cycle `mem_ready`=1: `ir_write`=1, `pc_write`=1, `pc_src`=00, then go to DECODE.
- DECODE:
  - Legal opcode: go to EXEC.
  - Illegal opcode: `illegal`=1 for this cycle, then go to FETCH.
- EXEC: `alu_op` and `alu_src` driven from `op_q`. `alu_src`=1 for addi/lw/lui/slti/sll/srl/sw. Next state by class:
  - beq: `pc_write`=`zero`, `pc_src`=01, then FETCH. Counter increments.
  - bne: `pc_write`=~`zero`, `pc_src`=01, then FETCH. Counter increments.
  - jmp: `pc_write`=1, `pc_src`=10, then FETCH. Counter increments.
  - lw/sw: go to MEM.
  - All others: go to WB.
- MEM: `iord`=1. `mem_read`=1 for lw, `mem_write`=1 for sw. Requests are held until `mem_ready`=1, then:
  - lw goes to WB.
  - sw goes to FETCH and the counter increments.
- WB: `reg_write`=1, then FETCH. Counter increments.
  - `mem_to_reg`=1 for lw only.
  - `reg_dst`=1 for R/and/or/xor only.
- Outputs not listed for a state are 0.
- `instr_count` wraps from 2^CNT_W−1 to 0.

## Timing
- Reset:
  - `rst_n` low immediately forces state INIT, `op_q`=0, `instr_count`=0.
  - Control outputs are decoded from the state, so all control outputs are 0 in INIT, including during reset.
  - This applies mid-instruction too: any pending memory request drops immediately.
- Cycle counts with zero-wait memory:
  - branch/jmp: 3
  - ALU ops: 4
  - sw: 4
  - lw: 5
- Each cycle `mem_ready` stays low adds one cycle in FETCH or MEM.
- `mem_ready` outside FETCH/MEM is ignored.
- Outputs are Moore-decoded from state and `op_q`, except the branch `pc_write`, which depends combinationally on `zero` in EXEC.
- `instr_count` updates on the clock edge that leaves the retiring state.

## Configuration
- `MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN`:
  - Defined: an illegal opcode in DECODE goes to TRAP. TRAP holds `illegal`=1 with all other outputs 0 and stays there until reset.
  - Undefined: the TRAP state does not exist. An illegal opcode pulses `illegal` for one cycle, is treated as a NOP, and returns to FETCH without incrementing the counter.

## Test plan
- Reset release, then addi (1) with `mem_ready` tied to 1 → state sequence 0,1,2,3,5,1. `alu_op`=0011 and `alu_src`=1 in EXEC; `reg_write`=1 in WB; `instr_count`=1.
- lw (6) with `mem_ready` low for 2 cycles in MEM → MEM lasts 3 cycles with `mem_read`=`iord`=1. WB has `mem_to_reg`=1. Total 7 cycles.
- beq (3) with `zero`=1, then bne (4) with `zero`=1 → `pc_write`=1 and `pc_src`=01 for beq only. Each takes 3 cycles.
- jmp (5) → `pc_write`=1 with `pc_src`=10 in EXEC. No `reg_write`.
- Opcode F:
  - Macro undefined: `illegal` pulses for one cycle, then back to FETCH, count unchanged.
  - Macro defined: state stays 6 and `illegal` stays 1 until `rst_n` is pulsed.
- With CNT_W=2: four sw (D) → `instr_count` 1,2,3,0. Assert `rst_n` low mid-MEM → `mem_write` drops immediately and state=0.
